salsa_loader: RTL and testbench

SALSA_LOADER -- requirements
Module: salsa_loader

---
 rtl/salsa_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_salsa_loader.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/salsa_loader.sv
// -----------------------------------------------------------------------------
// salsa_loader
//
// Serial loader / unloader for a bit-serial salsa mixing engine. Accepts
// 1024-bit X blocks on a valid/ready handshake, shifts them MSB first into the
// engine, starts the mix, and shifts the result back out into a 1024-bit
// output register that is presented on a valid/ready handshake. While the
// engine is busy, one further block may be prefetched into the engine's shift
// register, so back-to-back blocks restart without an engine reset.
//
// Ports
//   hash_clk    in   1     clock, all state on rising edge
//   reset_n     in   1     asynchronous active-low reset
//   in_data     in   1024  input X block, bit 1023 sent first
//   in_valid    in   1     input block valid
//   in_ready    out  1     loader can take a block
//   out_data    out  1024  salsa result, first bit from engine lands in bit 1023
//   out_valid   out  1     result valid, held until out_ready
//   out_ready   in   1     consumer takes the result
//   eng_din     out  1     serial data into the engine
//   eng_shift   out  1     engine shift enable
//   eng_start   out  1     one-cycle engine start
//   eng_reset   out  1     one-cycle active-high engine reset
//   eng_dout    in   1     serial data from the engine
//   eng_busy    in   1     engine is mixing
//   eng_result  in   1     engine holds a result in its shift register
//   err         out  1     sticky protocol-error flag
//
// States
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE      | waiting for a block (or a block held over from a collision)
//   FILL      | shifting the local block into an idle engine, 1024 cycles
//   START     | engine start pulse, engine loads its shift register
//   BUSY      | engine mixing; may accept one prefetch block
//   PREFETCH  | shifting the next block in while the engine mixes
//   WAIT_OUT  | result ready in engine; wait for the output register to free
//   DRAIN     | shifting the result out of the engine, 1024 cycles
//   RESTART   | start pulse that mixes the prefetched block
//   ERST      | engine reset pulse, clears its result flag before a fresh FILL
// -----------------------------------------------------------------------------
module salsa_loader (
    input  logic          hash_clk,
    input  logic          reset_n,
    input  logic [1023:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [1023:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          eng_din,
    output logic          eng_shift,
    output logic          eng_start,
    output logic          eng_reset,
    input  logic          eng_dout,
    input  logic          eng_busy,
    input  logic          eng_result,
    output logic          err
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FILL     = 4'd1;
    localparam logic [3:0] S_START    = 4'd2;
    localparam logic [3:0] S_BUSY     = 4'd3;
    localparam logic [3:0] S_PREFETCH = 4'd4;
    localparam logic [3:0] S_WAIT_OUT = 4'd5;
    localparam logic [3:0] S_DRAIN    = 4'd6;
    localparam logic [3:0] S_RESTART  = 4'd7;
    localparam logic [3:0] S_ERST     = 4'd8;

    logic [3:0]    state;
    logic [1023:0] blk_reg;
    logic [1023:0] res_reg;
    logic [9:0]    cnt;
    logic          next_loaded;
    // Block latched in BUSY on the same edge the result arrived; it is
    // filled from IDLE without a new handshake.
    logic          held;
    // Keeps in_ready low during reset and until the first edge after it.
    logic          live;
    logic          in_hs;
    logic          cnt_wrap;

    assign in_hs    = in_valid & in_ready;
    assign cnt_wrap = (cnt == 10'd1023);
    assign out_data = res_reg;

    always_comb begin
        in_ready = 1'b0;
        if (live) begin
            if (state == S_IDLE) begin
                in_ready = ~held;
            end else if (state == S_BUSY) begin
                in_ready = ~next_loaded;
            end
        end
    end

    // The prefetch shift is suppressed as soon as eng_result is seen: the
    // engine's shift register now holds the result, and one more shift would
    // corrupt it before the drain.
    always_comb begin
        eng_shift = 1'b0;
        eng_din   = 1'b0;
        eng_start = 1'b0;
        eng_reset = 1'b0;
        case (state)
            S_FILL: begin
                eng_shift = 1'b1;
                eng_din   = blk_reg[1023];
            end
            S_PREFETCH: begin
                eng_shift = ~eng_result;
                eng_din   = blk_reg[1023];
            end
            S_DRAIN:   eng_shift = 1'b1;
            S_START:   eng_start = 1'b1;
            S_RESTART: eng_start = 1'b1;
            S_ERST:    eng_reset = 1'b1;
            default: begin
                eng_shift = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            blk_reg     <= '0;
            res_reg     <= '0;
            cnt         <= '0;
            next_loaded <= 1'b0;
            held        <= 1'b0;
            live        <= 1'b0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            live <= 1'b1;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // An engine claiming busy and result together is inconsistent.
            if (eng_busy && eng_result) begin
                err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (held) begin
                        held  <= 1'b0;
                        state <= S_FILL;
                    end else if (in_hs) begin
                        blk_reg <= in_data;
                        state   <= S_FILL;
                    end
                end

                S_FILL: begin
                    blk_reg <= blk_reg << 1;
                    cnt     <= cnt + 10'd1;
                    if (cnt_wrap) begin
                        state <= S_START;
                    end
                end

                S_START: begin
                    next_loaded <= 1'b0;
                    state       <= S_BUSY;
                end

                S_BUSY: begin
                    if (in_hs) begin
                        blk_reg <= in_data;
                    end
                    if (eng_result) begin
                        held  <= in_hs;
                        state <= S_WAIT_OUT;
                    end else if (in_hs) begin
                        state <= S_PREFETCH;
                    end
                end

                S_PREFETCH: begin
                    if (eng_result) begin
                        // Engine finished before the prefetch did: drop the
                        // partial block and unload the result.
                        err         <= 1'b1;
                        next_loaded <= 1'b0;
                        cnt         <= '0;
                        state       <= S_WAIT_OUT;
                    end else begin
                        blk_reg <= blk_reg << 1;
                        cnt     <= cnt + 10'd1;
                        if (cnt_wrap) begin
                            next_loaded <= 1'b1;
                            state       <= S_BUSY;
                        end
                    end
                end

                S_WAIT_OUT: begin
                    if (!out_valid) begin
                        state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    res_reg <= {res_reg[1022:0], eng_dout};
                    cnt     <= cnt + 10'd1;
                    if (cnt_wrap) begin
                        out_valid <= 1'b1;
                        state     <= next_loaded ? S_RESTART : S_ERST;
                    end
                end

                S_RESTART: begin
                    next_loaded <= 1'b0;
                    state       <= S_BUSY;
                end

                S_ERST: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_salsa_loader.sv
module tb_salsa_loader;

    logic          hash_clk = 1'b0;
    logic          reset_n  = 1'b1;
    logic [1023:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          eng_din;
    logic          eng_shift;
    logic          eng_start;
    logic          eng_reset;
    logic          eng_dout;
    logic          eng_busy;
    logic          eng_result;
    logic          err;

    salsa_loader dut (
        .hash_clk   (hash_clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .eng_din    (eng_din),
        .eng_shift  (eng_shift),
        .eng_start  (eng_start),
        .eng_reset  (eng_reset),
        .eng_dout   (eng_dout),
        .eng_busy   (eng_busy),
        .eng_result (eng_result),
        .err        (err)
    );

    always #5 hash_clk = ~hash_clk;

    // Stand-in for the mixer: rotate left by 7 and xor a constant.
    function automatic logic [1023:0] salsa_fn(input logic [1023:0] x);
        return {x[1016:0], x[1023:1017]} ^ {32{32'hA5A5_5A5A}};
    endfunction

    // ---------------- engine model ----------------
    logic [1023:0] m_sh, m_nxt, m_cur;
    logic          m_busy, m_res;
    int            m_cnt;
    int            busy_len   = 9000;
    logic          force_done = 1'b0;

    assign eng_dout   = m_sh[1023];
    assign eng_busy   = m_busy;
    assign eng_result = m_res;

    always @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_sh   <= '0;
            m_nxt  <= '0;
            m_cur  <= '0;
            m_busy <= 1'b0;
            m_res  <= 1'b0;
            m_cnt  <= 0;
        end else if (eng_reset) begin
            m_res  <= 1'b0;
            m_busy <= 1'b0;
        end else if (eng_start) begin
            m_cur  <= m_res ? m_nxt : m_sh;
            m_busy <= 1'b1;
            m_res  <= 1'b0;
            m_cnt  <= busy_len;
        end else if (m_busy && (m_cnt <= 1 || force_done)) begin
            m_nxt  <= m_sh;
            m_sh   <= salsa_fn(m_cur);
            m_res  <= 1'b1;
            m_busy <= 1'b0;
        end else begin
            if (m_busy) m_cnt <= m_cnt - 1;
            if (eng_shift) m_sh <= {m_sh[1022:0], eng_din};
        end
    end

    // ---------------- monitor (samples on falling edge) ----------------
    int            cyc = 0;
    int            n_shift = 0, n_shift_busy = 0, n_start = 0, n_restart = 0;
    int            n_rst = 0, n_overlap = 0, n_unstable = 0;
    int            last_shift_cyc = 0, restart_gap = 0;
    int            out_n = 0;
    logic [1023:0] out_log [0:15];
    logic          prev_valid = 1'b0;
    logic [1023:0] prev_data;

    always @(negedge hash_clk) begin
        cyc <= cyc + 1;
        if (reset_n) begin
            if (eng_shift) begin
                n_shift        <= n_shift + 1;
                last_shift_cyc <= cyc;
                if (eng_busy) n_shift_busy <= n_shift_busy + 1;
            end
            if (eng_start) n_start <= n_start + 1;
            if (eng_start && eng_result) begin
                n_restart   <= n_restart + 1;
                restart_gap <= cyc - last_shift_cyc;
            end
            if (eng_reset) n_rst <= n_rst + 1;
            if (eng_start && eng_shift) n_overlap <= n_overlap + 1;
            if (out_valid && prev_valid && out_data !== prev_data) n_unstable <= n_unstable + 1;
            if (out_valid && out_ready && out_n < 16) begin
                out_log[out_n] <= out_data;
                out_n          <= out_n + 1;
            end
            prev_valid <= out_valid;
            prev_data  <= out_data;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    task automatic check_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        int hi;
        hi = -1;
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            for (int i = 0; i < 1024; i++) if (act[i] !== exp[i]) hi = i;
            $display("FAIL %s: got[127:0]=%h want[127:0]=%h top_diff_bit=%0d",
                     name, act[127:0], exp[127:0], hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge hash_clk);
        #1;
    endtask

    task automatic send(input string name, input logic [1023:0] blk);
        int k;
        logic got;
        k = 0;
        got = 1'b0;
        in_data  = blk;
        in_valid = 1'b1;
        while (!got && k < 40000) begin
            @(negedge hash_clk);
            if (in_ready) got = 1'b1;
            k++;
        end
        @(posedge hash_clk);
        #1;
        in_valid = 1'b0;
        check_bit(name, got, 1'b1);
    endtask

    task automatic wait_outs(input string name, input int target);
        int k;
        k = 0;
        while (out_n < target && k < 40000) begin
            @(negedge hash_clk); #1; k++;
        end
        check_int(name, out_n, target);
    endtask

    task automatic wait_rst(input string name, input int target);
        int k;
        k = 0;
        while (n_rst < target && k < 40000) begin
            @(negedge hash_clk); #1; k++;
        end
        check_int(name, n_rst, target);
    endtask

    task automatic wait_start(input int target);
        int k;
        k = 0;
        while (n_start < target && k < 40000) begin
            @(negedge hash_clk); #1; k++;
        end
        check_int("start_seen", n_start, target);
    endtask

    typedef struct {
        logic [1023:0] blk;
        int            blen;
        logic [1023:0] exp;
    } vec_t;

    vec_t vecs [4];
    int b_shift, b_busy, b_start, b_restart, b_rst, b_out;
    logic [1023:0] blk_a, blk_b, blk_c;

    task automatic snap();
        b_shift   = n_shift;
        b_busy    = n_shift_busy;
        b_start   = n_start;
        b_restart = n_restart;
        b_rst     = n_rst;
        b_out     = out_n;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        vecs[0].blk = '0;
        vecs[0].blen = 9000;
        vecs[1].blk = '1;
        vecs[1].blen = 1500;
        vecs[2].blk = {1'b1, 1022'b0, 1'b1};
        vecs[2].blen = 1500;
        vecs[3].blk = {16{64'hDEAD_BEEF_0123_4567}};
        vecs[3].blen = 1500;
        for (int i = 0; i < 4; i++) vecs[i].exp = salsa_fn(vecs[i].blk);

        blk_a = {32{32'h1357_9BDF}};
        blk_b = {8{128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0}};
        blk_c = {64{16'hC0DE}};

        // reset values
        #2 reset_n = 1'b0;
        #1;
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_eng_shift", eng_shift, 1'b0);
        check_bit("rst_eng_start", eng_start, 1'b0);
        check_bit("rst_eng_reset", eng_reset, 1'b0);
        check_bit("rst_eng_din", eng_din, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_blk("rst_out_data", out_data, '0);
        repeat (3) @(posedge hash_clk);
        @(negedge hash_clk);
        reset_n = 1'b1;
        #1 check_bit("in_ready_before_edge", in_ready, 1'b0);
        tick(1);
        check_bit("in_ready_after_reset", in_ready, 1'b1);

        // single blocks, table driven
        for (int i = 0; i < 4; i++) begin
            busy_len = vecs[i].blen;
            snap();
            send($sformatf("vec%0d_handshake", i), vecs[i].blk);
            wait_outs($sformatf("vec%0d_out", i), b_out + 1);
            wait_rst($sformatf("vec%0d_eng_reset", i), b_rst + 1);
            tick(3);
            check_blk($sformatf("vec%0d_result", i), out_log[b_out], vecs[i].exp);
            check_int($sformatf("vec%0d_shifts", i), n_shift - b_shift, 2048);
            check_int($sformatf("vec%0d_starts", i), n_start - b_start, 1);
            check_int($sformatf("vec%0d_resets", i), n_rst - b_rst, 1);
            check_int($sformatf("vec%0d_busy_shifts", i), n_shift_busy - b_busy, 0);
            check_bit($sformatf("vec%0d_err", i), err, 1'b0);
        end

        // back-to-back with prefetch
        busy_len = 2500;
        snap();
        send("b2b_a", blk_a);
        wait_start(b_start + 1);
        send("b2b_b", blk_b);
        wait_outs("b2b_outs", b_out + 2);
        wait_rst("b2b_reset", b_rst + 1);
        tick(3);
        check_blk("b2b_result_a", out_log[b_out], salsa_fn(blk_a));
        check_blk("b2b_result_b", out_log[b_out + 1], salsa_fn(blk_b));
        check_int("b2b_prefetch_shifts", n_shift_busy - b_busy, 1024);
        check_int("b2b_starts", n_start - b_start, 2);
        check_int("b2b_restarts", n_restart - b_restart, 1);
        check_int("b2b_restart_gap", restart_gap, 1);
        check_int("b2b_resets", n_rst - b_rst, 1);
        check_bit("b2b_err", err, 1'b0);

        // output backpressure
        out_ready = 1'b0;
        snap();
        send("bp_a", blk_b);
        wait_start(b_start + 1);
        send("bp_b", blk_a);
        begin
            int k;
            k = 0;
            while (!out_valid && k < 20000) begin
                @(negedge hash_clk); #1; k++;
            end
        end
        tick(5000);
        check_bit("bp_valid_held", out_valid, 1'b1);
        check_blk("bp_data_held", out_data, salsa_fn(blk_b));
        check_int("bp_shifts_stalled", n_shift - b_shift, 3072);
        check_int("bp_no_early_take", out_n - b_out, 0);
        out_ready = 1'b1;
        wait_outs("bp_outs", b_out + 2);
        wait_rst("bp_reset", b_rst + 1);
        tick(3);
        check_blk("bp_result_first", out_log[b_out], salsa_fn(blk_b));
        check_blk("bp_result_second", out_log[b_out + 1], salsa_fn(blk_a));

        // engine finishes during prefetch
        busy_len = 4000;
        snap();
        send("er_a", blk_c);
        wait_start(b_start + 1);
        send("er_b", blk_a);
        tick(100);
        force_done = 1'b1;
        tick(1);
        force_done = 1'b0;
        tick(3);
        check_bit("er_err_set", err, 1'b1);
        wait_outs("er_outs", b_out + 1);
        wait_rst("er_reset", b_rst + 1);
        tick(50);
        check_blk("er_result", out_log[b_out], salsa_fn(blk_c));
        check_bit("er_err_sticky", err, 1'b1);
        check_int("er_starts", n_start - b_start, 1);
        check_bit("er_partial", (n_shift_busy - b_busy) < 1024, 1'b1);

        // handshake on the cycle the result appears
        busy_len = 4000;
        snap();
        send("col_a", blk_a);
        wait_start(b_start + 1);
        tick(200);
        force_done = 1'b1;
        tick(1);
        force_done = 1'b0;
        in_data  = blk_c;
        in_valid = 1'b1;
        check_bit("col_result_up", eng_result, 1'b1);
        check_bit("col_in_ready", in_ready, 1'b1);
        tick(1);
        in_valid = 1'b0;
        check_bit("col_ready_dropped", in_ready, 1'b0);
        wait_outs("col_outs", b_out + 2);
        wait_rst("col_resets", b_rst + 2);
        tick(3);
        check_blk("col_result_a", out_log[b_out], salsa_fn(blk_a));
        check_blk("col_result_b", out_log[b_out + 1], salsa_fn(blk_c));
        check_int("col_starts", n_start - b_start, 2);
        check_int("col_restarts", n_restart - b_restart, 0);
        check_int("col_shifts", n_shift - b_shift, 4096);

        // async reset in the middle of FILL
        busy_len = 1500;
        snap();
        send("ar_a", blk_a);
        begin
            int k;
            k = 0;
            while ((n_shift - b_shift) < 500 && k < 5000) begin
                @(negedge hash_clk); #1; k++;
            end
        end
        check_bit("ar_mid_fill", eng_shift, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check_bit("ar_in_ready", in_ready, 1'b0);
        check_bit("ar_out_valid", out_valid, 1'b0);
        check_bit("ar_eng_shift", eng_shift, 1'b0);
        check_bit("ar_eng_start", eng_start, 1'b0);
        check_bit("ar_eng_reset", eng_reset, 1'b0);
        check_bit("ar_eng_din", eng_din, 1'b0);
        check_bit("ar_err_cleared", err, 1'b0);
        tick(2);
        @(negedge hash_clk);
        reset_n = 1'b1;
        tick(1);
        check_bit("ar_in_ready_back", in_ready, 1'b1);
        snap();
        send("ar_c", blk_c);
        wait_outs("ar_outs", b_out + 1);
        wait_rst("ar_reset", b_rst + 1);
        tick(3);
        check_blk("ar_result", out_log[b_out], salsa_fn(blk_c));
        check_int("ar_shifts", n_shift - b_shift, 2048);

        check_int("no_start_shift_overlap", n_overlap, 0);
        check_int("out_data_stable", n_unstable, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
